// File: rtl/vx_mem_req_arb.sv
// vx_mem_req_arb: round-robin merge of NUM_REQS memory request streams into one registered port,
// with responses routed back to their requester by the index carried in the tag LSBs.
module vx_mem_req_arb #(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 8,
    localparam int DATA_SIZE     = DATA_WIDTH / 8,
    localparam int LOG_NUM_REQS  = $clog2(NUM_REQS),
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQS-1:0]      req_in_valid,
    input  logic [NUM_REQS-1:0]      req_in_rw,
    input  logic [DATA_SIZE-1:0]     req_in_byteen [NUM_REQS],
    input  logic [ADDR_WIDTH-1:0]    req_in_addr [NUM_REQS],
    input  logic [DATA_WIDTH-1:0]    req_in_data [NUM_REQS],
    input  logic [TAG_IN_WIDTH-1:0]  req_in_tag [NUM_REQS],
    output logic [NUM_REQS-1:0]      req_in_ready,
    output logic                     req_out_valid,
    output logic                     req_out_rw,
    output logic [DATA_SIZE-1:0]     req_out_byteen,
    output logic [ADDR_WIDTH-1:0]    req_out_addr,
    output logic [DATA_WIDTH-1:0]    req_out_data,
    output logic [TAG_OUT_WIDTH-1:0] req_out_tag,
    input  logic                     req_out_ready,
    input  logic                     rsp_in_valid,
    input  logic [DATA_WIDTH-1:0]    rsp_in_data,
    input  logic [TAG_OUT_WIDTH-1:0] rsp_in_tag,
    output logic                     rsp_in_ready,
    output logic [NUM_REQS-1:0]      rsp_out_valid,
    output logic [DATA_WIDTH-1:0]    rsp_out_data [NUM_REQS],
    output logic [TAG_IN_WIDTH-1:0]  rsp_out_tag [NUM_REQS],
    input  logic [NUM_REQS-1:0]      rsp_out_ready
);
    logic [LOG_NUM_REQS-1:0] ptr;
    logic [LOG_NUM_REQS-1:0] grant;
    logic [LOG_NUM_REQS-1:0] grant_next;
    logic [LOG_NUM_REQS-1:0] rsp_idx;
    logic                    load_en;
    logic                    grant_en;

    // Scan downward so the first valid requester at or after p is the one left in pick.
    function automatic logic [LOG_NUM_REQS-1:0] rr_pick(
        input logic [NUM_REQS-1:0]     v,
        input logic [LOG_NUM_REQS-1:0] p
    );
        logic [LOG_NUM_REQS-1:0] pick;
        logic [LOG_NUM_REQS-1:0] idx;
        pick = p;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(p) + k >= NUM_REQS) ? LOG_NUM_REQS'(int'(p) + k - NUM_REQS)
                                            : LOG_NUM_REQS'(int'(p) + k);
            if (v[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign load_en    = !req_out_valid || req_out_ready;
    assign grant      = rr_pick(req_in_valid, ptr);
    assign grant_en   = load_en && (|req_in_valid) && !reset;
    assign grant_next = (grant == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant + LOG_NUM_REQS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            req_out_valid <= 1'b0;
            ptr           <= '0;
        end else if (load_en) begin
            req_out_valid <= grant_en;
            ptr           <= grant_en ? grant_next : ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_en) begin
            req_out_rw     <= req_in_rw[grant];
            req_out_byteen <= req_in_byteen[grant];
            req_out_addr   <= req_in_addr[grant];
            req_out_data   <= req_in_data[grant];
            req_out_tag    <= {req_in_tag[grant], grant};
        end
    end

    assign rsp_idx      = rsp_in_tag[LOG_NUM_REQS-1:0];
    assign rsp_in_ready = (int'(rsp_idx) < NUM_REQS) ? rsp_out_ready[rsp_idx] : 1'b0;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_port
        assign req_in_ready[i]  = grant_en && (grant == LOG_NUM_REQS'(i));
        assign rsp_out_valid[i] = rsp_in_valid && (rsp_idx == LOG_NUM_REQS'(i));
        assign rsp_out_data[i]  = rsp_in_data;
        assign rsp_out_tag[i]   = rsp_in_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS];
    end
endmodule

// File: doc/vx_mem_req_arb.md
VX_MEM_REQ_ARB -- requirements
Module: VX_mem_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requesters (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, request/response data bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26, address bits.
REQ-004 SHALL have parameter TAG_IN_WIDTH, default 8, per-requester tag bits.
REQ-005 SHALL have derived parameters:
- DATA_SIZE = DATA_WIDTH/8
- LOG_NUM_REQS = clog2(NUM_REQS)
- TAG_OUT_WIDTH = TAG_IN_WIDTH+LOG_NUM_REQS
REQ-006 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
REQ-007 SHALL have these request-side ports (per-requester arrays indexed [NUM_REQS]):
- req_in_valid  in  [NUM_REQS]  request valid
- req_in_rw  in  [NUM_REQS]  1=write
- req_in_byteen  in  [NUM_REQS][DATA_SIZE]  byte enables
- req_in_addr  in  [NUM_REQS][ADDR_WIDTH]  address
- req_in_data  in  [NUM_REQS][DATA_WIDTH]  write data
- req_in_tag  in  [NUM_REQS][TAG_IN_WIDTH]  tag
- req_in_ready  out  [NUM_REQS]  request accepted
- req_out_valid  out  1  merged request valid
- req_out_rw  out  1  rw
- req_out_byteen  out  DATA_SIZE  byte enables
- req_out_addr  out  ADDR_WIDTH  address
- req_out_data  out  DATA_WIDTH  data
- req_out_tag  out  TAG_OUT_WIDTH  {tag, requester index}
- req_out_ready  in  1  downstream accepts
REQ-008 SHALL have these response-side ports:
- rsp_in_valid  in  1  response valid
- rsp_in_data  in  DATA_WIDTH  read data
- rsp_in_tag  in  TAG_OUT_WIDTH  returned tag
- rsp_in_ready  out  1  response accepted
- rsp_out_valid  out  [NUM_REQS]  routed response valid
- rsp_out_data  out  [NUM_REQS][DATA_WIDTH]  read data
- rsp_out_tag  out  [NUM_REQS][TAG_IN_WIDTH]  original tag
- rsp_out_ready  in  [NUM_REQS]  requester accepts

Function
REQ-009 SHALL hold req_out_* in a one-entry output register; req_out_* fields SHALL be register outputs.
REQ-010 SHALL define load_en = !req_out_valid || req_out_ready, computed combinationally each cycle.
REQ-011 SHALL pick winner g when load_en and any req_in_valid is set:
- round-robin search starting at pointer ptr, wrapping NUM_REQS-1 -> 0
- req_in_ready[g]=1; all other req_in_ready=0
- with no valid requester or !load_en, all req_in_ready=0
REQ-012 SHALL, on grant, load the register next edge:
- req_out_valid=1
- rw/byteen/addr/data copied from requester g
- req_out_tag = {req_in_tag[g], g[LOG_NUM_REQS-1:0]}
- ptr = (g+1) mod NUM_REQS
REQ-013 SHALL clear req_out_valid next edge when req_out_ready=1 and no grant occurs; ptr unchanged.
REQ-014 SHALL keep all req_out_* stable while req_out_valid=1 and req_out_ready=0.
REQ-015 SHALL sustain one request per cycle: accept-out and load-new in the same cycle; latency req_in handshake -> req_out_valid is exactly 1 cycle.
REQ-016 SHALL route responses combinationally:
- i = rsp_in_tag[LOG_NUM_REQS-1:0]
- rsp_out_valid[i] = rsp_in_valid; all others 0
- rsp_out_tag[i] = rsp_in_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS]
- rsp_out_data[i] = rsp_in_data
- rsp_in_ready = rsp_out_ready[i]
REQ-017 SHALL treat request and response paths as independent; simultaneous activity on both SHALL not interact.
REQ-018 SHALL, with a starving requester continuously valid, grant it within NUM_REQS grants.

Reset
REQ-019 SHALL on reset set req_out_valid=0 and ptr=0; other req_out_* fields don't-care.
REQ-020 SHALL keep all req_in_ready=0 during the reset cycle.
REQ-021 SHALL discard a buffered request when reset is asserted mid-operation.
REQ-022 SHALL leave the response path combinational and unaffected by reset.

Verification
REQ-023 Reset, then all 4 requesters valid and req_out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; req_out_tag LSBs 0,1,2,3,0.
REQ-024 Only requester 2 valid, tag 0x5A -> next cycle req_out_valid=1, req_out_tag=0x16A.
REQ-025 Request buffered, req_out_ready=0 for 3 cycles -> req_out_* constant, all req_in_ready=0; ready=1 -> new winner loaded same cycle.
REQ-026 rsp_in_valid=1, rsp_in_tag=0x16A, rsp_out_ready[2]=0 -> rsp_out_valid=0b0100, rsp_out_tag[2]=0x5A, rsp_in_ready=0; then ready[2]=1 -> rsp_in_ready=1.
REQ-027 Reset asserted while request buffered and req_out_ready=0 -> next cycle req_out_valid=0; next grant with all valid goes to requester 0.
